control_unit_bist: RTL and testbench

Built-in self-test engine for the control unit. It drives the unit's `op`/`func` inputs from the other end of the interface, sweeping every opcode and every R-type function code. Each cycle it compresses the decoded control word into a 32-bit MISR signature and compares the final signature against a golden constant. It sits beside the control unit in the datapath and takes over `op`/`func` through an external mux while `busy` is high; it is also used standalone in the control unit bench.

---
 rtl/control_unit_bist.sv | 132 +++++++++++++
 tb/tb_control_unit_bist.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_bist.sv
// control_unit_bist
// Built-in self-test engine for the control unit. It drives every opcode and
// every R-type function code into the unit, one vector per clock. Each cycle
// it folds the decoded control word into a 32-bit MISR. When the sweep ends
// it compares the final signature with a golden constant.
//
// Ports
//   CLK, RST     clock; synchronous active-high reset
//   start        begin a sweep (honoured in IDLE or DONE only)
//   op, func     vector driven to the control unit (registered)
//   ALUOp .. halt decoded control unit outputs, compressed every RUN cycle
//   busy         high while sweeping
//   done         high once a sweep has completed
//   pass         final signature matched EXPECTED_SIG (valid with done)
//   signature    current MISR contents
module control_unit_bist #(
    parameter logic [31:0] EXPECTED_SIG = 32'h0000_0000,
    parameter logic [31:0] SEED         = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    output logic [5:0]  op,
    output logic [5:0]  func,
    input  logic [3:0]  ALUOp,
    input  logic        ExtOp,
    input  logic [1:0]  MemtoReg,
    input  logic [1:0]  PCSrc,
    input  logic        RegDst,
    input  logic        RegWr,
    input  logic        ALUSrc,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        shift,
    input  logic        jal,
    input  logic        branch,
    input  logic        halt,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [31:0] signature
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  op_nxt, func_nxt;
    logic [31:0] sig_nxt, sig_step;
    logic        pass_nxt;
    logic [17:0] cw;

    // One MISR step: shift left, fold in the feedback taps when the MSB
    // falls out, then XOR in the control word.
    function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                              input logic [17:0] word);
        logic [31:0] fb;
        fb = sig[31] ? 32'h0040_0007 : 32'h0000_0000;
        return {sig[30:0], 1'b0} ^ fb ^ {14'b0, word};
    endfunction

    assign cw = {ALUOp, ExtOp, MemtoReg, PCSrc, RegDst, RegWr, ALUSrc,
                 MemRd, MemWr, shift, jal, branch, halt};

    assign sig_step = misr_step(signature, cw);

    // Status flags decode directly from the state flops.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        func_nxt  = func;
        sig_nxt   = signature;
        pass_nxt  = pass;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    op_nxt    = 6'd0;
                    func_nxt  = 6'd0;
                    sig_nxt   = SEED;
                    pass_nxt  = 1'b0;
                end
            end
            RUN: begin
                sig_nxt = sig_step;
                if (op == 6'd63) begin
                    // Last vector is compressed on this edge. The verdict uses
                    // the signature that is being written, not the stale one.
                    state_nxt = DONE;
                    op_nxt    = 6'd0;
                    func_nxt  = 6'd0;
                    pass_nxt  = (sig_step == EXPECTED_SIG);
                end else if (op == 6'd0 && func != 6'd63) begin
                    func_nxt = func + 6'd1;
                end else begin
                    // The R-type sweep is finished (or already past it).
                    // Step the opcode with func held at 0.
                    op_nxt   = op + 6'd1;
                    func_nxt = 6'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                op_nxt    = 6'd0;
                func_nxt  = 6'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            op        <= 6'd0;
            func      <= 6'd0;
            signature <= SEED;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            op        <= op_nxt;
            func      <= func_nxt;
            signature <= sig_nxt;
            pass      <= pass_nxt;
        end
    end

endmodule

// File: tb/tb_control_unit_bist.sv
// tb_control_unit_bist
// Bench for control_unit_bist. A stand-in control unit decodes op/func, and
// optional faults can be injected into that decode. The golden signature
// comes from a vector-list model of the whole sweep.
module tb_control_unit_bist;

    localparam logic [31:0] SEED_V = 32'hFFFF_FFFF;

    // Stand-in combinational control unit. The fault argument selects an
    // optional corruption of the decode.
    function automatic logic [17:0] dec(input logic [5:0] o, input logic [5:0] f,
                                        input int fault);
        logic [3:0] aluop;
        logic       ext, rdst, regwr, alusrc, memrd, memwr, sh, jl, br, hl;
        logic [1:0] m2r, pcs;
        aluop  = (o == 6'd0) ? (f[3:0] ^ {f[5], f[5], f[4], f[4]}) : (o[3:0] ^ 4'h9);
        ext    = o[0];
        m2r    = o[2:1];
        pcs    = o[5:4];
        rdst   = (o == 6'd0);
        regwr  = (o == 6'd0) | (o[5:3] == 3'b001);
        alusrc = (o != 6'd0);
        memrd  = (o == 6'h23);
        memwr  = (o == 6'h2b);
        sh     = (o == 6'd0) && (f[5:2] == 4'd0);
        jl     = (o == 6'd3);
        br     = (o == 6'd4) || (o == 6'd5);
        hl     = (o == 6'h3f);
        if (fault == 1 && o == 6'h23) regwr = 1'b1;
        if (fault == 2 && f == 6'h21) aluop[0] = ~aluop[0];
        return {aluop, ext, m2r, pcs, rdst, regwr, alusrc, memrd, memwr, sh, jl, br, hl};
    endfunction

    // Whole-sweep model. It builds the 127-entry vector list by arithmetic and
    // folds each control word into the polynomial signature.
    function automatic logic [31:0] model_sig(input logic [31:0] seed, input int fault);
        logic [31:0] s;
        logic [5:0]  o, f;
        logic [17:0] w;
        s = seed;
        for (int i = 0; i < 127; i++) begin
            if (i < 64) begin
                o = 6'd0;
                f = 6'(i);
            end else begin
                o = 6'(i - 63);
                f = 6'd0;
            end
            w = dec(o, f, fault);
            s = {s[30:0], 1'b0} ^ ({32{s[31]}} & 32'h0040_0007) ^ {14'b0, w};
        end
        return s;
    endfunction

    localparam logic [31:0] GOLD = model_sig(SEED_V, 0);

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  op, func;
    logic [3:0]  ALUOp;
    logic        ExtOp, RegDst, RegWr, ALUSrc, MemRd, MemWr, shift, jal, branch, halt;
    logic [1:0]  MemtoReg, PCSrc;
    logic        busy, done, pass;
    logic [31:0] signature;
    logic [17:0] cu_word;
    int          fault_mode = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 CLK = ~CLK;

    assign cu_word = dec(op, func, fault_mode);
    assign {ALUOp, ExtOp, MemtoReg, PCSrc, RegDst, RegWr, ALUSrc,
            MemRd, MemWr, shift, jal, branch, halt} = cu_word;

    control_unit_bist #(.EXPECTED_SIG(GOLD), .SEED(SEED_V)) dut (
        .CLK(CLK), .RST(RST), .start(start),
        .op(op), .func(func),
        .ALUOp(ALUOp), .ExtOp(ExtOp), .MemtoReg(MemtoReg), .PCSrc(PCSrc),
        .RegDst(RegDst), .RegWr(RegWr), .ALUSrc(ALUSrc), .MemRd(MemRd),
        .MemWr(MemWr), .shift(shift), .jal(jal), .branch(branch), .halt(halt),
        .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_op"}, 32'(op), 32'd0);
        check({tag, "_func"}, 32'(func), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_sig"}, signature, SEED_V);
    endtask

    // One full sweep from IDLE or DONE. The vector sequence is checked against
    // the index arithmetic, then the length, the signature and the verdict.
    task automatic do_sweep(input int fault, input bit hold_start);
        int          cyc;
        int          seq_bad;
        logic [5:0]  eo, ef;
        logic [31:0] exp_sig;
        fault_mode = fault;
        start = 1'b1;
        tick();
        start = hold_start;
        check("busy_rise", 32'(busy), 32'd1);
        cyc = 0;
        seq_bad = 0;
        while (busy && cyc < 300) begin
            eo = (cyc < 64) ? 6'd0 : 6'(cyc - 63);
            ef = (cyc < 64) ? 6'(cyc) : 6'd0;
            if (op !== eo || func !== ef) seq_bad++;
            tick();
            cyc++;
        end
        start = 1'b0;
        exp_sig = model_sig(SEED_V, fault);
        check("sweep_len", 32'(cyc), 32'd127);
        check("vec_seq", 32'(seq_bad), 32'd0);
        check("done_rise", 32'(done), 32'd1);
        check("final_sig", signature, exp_sig);
        check("pass", 32'(pass), 32'(exp_sig == GOLD));
        check("op_after", 32'(op), 32'd0);
        check("func_after", 32'(func), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          bad;
        int          n;
        int          abort_at;
        logic [31:0] held_sig;

        // Reset and idle hold
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        check_reset_vals("reset");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
                signature !== SEED_V || op !== 6'd0 || func !== 6'd0) bad++;
        end
        check("idle_hold", 32'(bad), 32'd0);

        // Reset and start on the same edge
        RST = 1'b1;
        start = 1'b1;
        tick();
        RST = 1'b0;
        start = 1'b0;
        check_reset_vals("rst_start");
        tick();
        check("rst_start_stay", 32'(busy), 32'd0);

        // Golden sweep, then a random DONE hold
        do_sweep(0, 1'b0);
        n = $urandom_range(1, 8);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done !== 1'b1 || busy !== 1'b0 || signature !== GOLD || pass !== 1'b1) bad++;
        end
        check("done_hold", 32'(bad), 32'd0);

        // Restart from DONE with start held high through RUN
        do_sweep(0, 1'b1);

        // Fault injection
        do_sweep(1, 1'b0);
        check("f1_sig_ne", 32'(signature != GOLD), 32'd1);
        do_sweep(2, 1'b0);
        check("f2_sig_ne", 32'(signature != GOLD), 32'd1);
        do_sweep(0, 1'b0);

        // Reset at the 50th RUN cycle
        fault_mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (49) tick();
        check("mid_busy", 32'(busy), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_reset_vals("abort50");
        do_sweep(0, 1'b0);

        // Randomized rounds: random gap, fault, start hold, and optional abort
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 5)) tick();
            if ($urandom_range(0, 1) == 1) begin
                abort_at = $urandom_range(1, 126);
                start = 1'b1;
                tick();
                start = 1'($urandom_range(0, 1));
                repeat (abort_at - 1) tick();
                RST = 1'b1;
                tick();
                RST = 1'b0;
                start = 1'b0;
                check_reset_vals("rand_abort");
            end
            do_sweep($urandom_range(0, 2), 1'($urandom_range(0, 1)));
            held_sig = model_sig(SEED_V, fault_mode);
            tick();
            check("rand_hold_sig", signature, held_sig);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
